// File: rtl/sprite_overlay_pkg.sv
// rtl/sprite_overlay_pkg.sv - shared mode encodings, colour type and default palette for the sprite overlay
package sprite_overlay_pkg;

  typedef enum logic [1:0] {
    OV_STATIC = 2'd0,
    OV_ALT    = 2'd1,
    OV_BLINK  = 2'd2,
    OV_RSVD   = 2'd3
  } ov_mode_e;

  typedef logic [11:0] rgb444_t;

  localparam rgb444_t BG_DEFAULT   = 12'h7CC;
  localparam rgb444_t FG_A_DEFAULT = 12'h836;
  localparam rgb444_t FG_B_DEFAULT = 12'hF53;

  // The reserved encoding behaves exactly like STATIC, so fold it at latch time
  function automatic ov_mode_e decode_mode(input logic [1:0] m);
    return (m == 2'd3) ? OV_STATIC : ov_mode_e'(m);
  endfunction

endpackage

// File: rtl/sprite_overlay_if.sv
// rtl/sprite_overlay_if.sv - pixel-path interface between the timing generator and the sprite overlay
interface sprite_overlay_if;
  logic [10:0] pos_x;
  logic [10:0] pos_y;
  logic        frame_tick;
  logic        enable;
  logic [1:0]  mode;
  logic [3:0]  ov_r;
  logic [3:0]  ov_g;
  logic [3:0]  ov_b;
  logic        in_region;
  logic        hit;

  modport master (
    output pos_x, pos_y, frame_tick, enable, mode,
    input  ov_r, ov_g, ov_b, in_region, hit
  );

  modport slave (
    input  pos_x, pos_y, frame_tick, enable, mode,
    output ov_r, ov_g, ov_b, in_region, hit
  );
endinterface

// File: rtl/sprite_overlay_mask_rom.sv
// rtl/sprite_overlay_mask_rom.sv - 1-bit mask ROM with registered output and configurable read latency
module sprite_overlay_mask_rom #(
  parameter int ADDR_W  = 19,
  parameter int ROM_LAT = 1
) (
  input  logic              i_clk,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              o_mask
);

  // Built-in content: mask bit is the parity of address bits 4 and 11, giving a
  // regular opaque/transparent pattern with address 0 opaque. Replace with a BRAM
  // initialisation for real artwork.
  localparam logic [ADDR_W-1:0] PAT_TAPS = ADDR_W'(12'h810);

  logic [ROM_LAT-1:0] r_pipe;

  // Read register plus optional extra output register, like a BRAM with DOB_REG
  always_ff @(posedge i_clk) begin
    r_pipe[0] <= ^(i_addr & PAT_TAPS);
    for (int i = 1; i < ROM_LAT; i++) begin
      r_pipe[i] <= r_pipe[i-1];
    end
  end

  assign o_mask = r_pipe[ROM_LAT-1];

endmodule

// File: rtl/sprite_overlay.sv
// rtl/sprite_overlay.sv - 1-bpp sprite overlay with per-frame colour animation and fixed pipeline latency
module sprite_overlay
  import sprite_overlay_pkg::*;
#(
  parameter int      X0       = 350,
  parameter int      Y0       = 100,
  parameter int      W        = 740,
  parameter int      H        = 650,
  parameter int      ROM_LAT  = 1,
  parameter int      PERIOD   = 60,
  parameter rgb444_t BG_COLOR = BG_DEFAULT,
  parameter rgb444_t FG_A     = FG_A_DEFAULT,
  parameter rgb444_t FG_B     = FG_B_DEFAULT
) (
  input  logic            i_clk,
  input  logic            i_rst,
  sprite_overlay_if.slave bus
);

  localparam int ADDR_W = $clog2(W * H);
  localparam int CNT_W  = $clog2(PERIOD);

  // Bounds widened to 12 bits so X0+W / Y0+H never wrap
  localparam logic [11:0] X_LO = 12'(X0);
  localparam logic [11:0] X_HI = 12'(X0 + W);
  localparam logic [11:0] Y_LO = 12'(Y0);
  localparam logic [11:0] Y_HI = 12'(Y0 + H);
  localparam logic [10:0] X0_11 = 11'(X0);
  localparam logic [10:0] Y0_11 = 11'(Y0);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(PERIOD - 1);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(PERIOD / 2);

  logic              w_region;
  logic [10:0]       w_dx;
  logic [10:0]       w_dy;
  logic [ADDR_W-1:0] w_addr;
  logic [ADDR_W-1:0] r_addr;
  logic              r_region;
  logic [ROM_LAT-1:0] r_reg_dly;
  logic              w_reg_d;
  logic              w_mask;
  logic [CNT_W-1:0]  r_frame_cnt;
  ov_mode_e          r_mode_q;
  ov_mode_e          w_mode_next;
  logic              w_phase;
  rgb444_t           w_color;
  logic              w_hit;

  // Region test and linear mask address; address parked at 0 outside the sprite
  always_comb begin
    w_region = bus.enable
            && ({1'b0, bus.pos_x} >= X_LO) && ({1'b0, bus.pos_x} < X_HI)
            && ({1'b0, bus.pos_y} >= Y_LO) && ({1'b0, bus.pos_y} < Y_HI);
    w_dx   = bus.pos_x - X0_11;
    w_dy   = bus.pos_y - Y0_11;
    w_addr = w_region ? (ADDR_W'(w_dy) * ADDR_W'(W) + ADDR_W'(w_dx)) : '0;
  end

  // Stage 0: register address and region flag
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_addr   <= '0;
      r_region <= 1'b0;
    end else begin
      r_addr   <= w_addr;
      r_region <= w_region;
    end
  end

  sprite_overlay_mask_rom #(
    .ADDR_W (ADDR_W),
    .ROM_LAT(ROM_LAT)
  ) u_rom (
    .i_clk (i_clk),
    .i_addr(r_addr),
    .o_mask(w_mask)
  );

  // Region flag delay line kept in step with the ROM read latency
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_reg_dly <= '0;
    end else begin
      r_reg_dly[0] <= r_region;
      for (int i = 1; i < ROM_LAT; i++) begin
        r_reg_dly[i] <= r_reg_dly[i-1];
      end
    end
  end

  assign w_reg_d     = r_reg_dly[ROM_LAT-1];
  assign w_mode_next = decode_mode(bus.mode);

  // Frame counter and mode latch; a mode change restarts the animation at phase A
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_frame_cnt <= '0;
      r_mode_q    <= OV_STATIC;
    end else if (bus.frame_tick) begin
      r_mode_q <= w_mode_next;
      if ((w_mode_next != r_mode_q) || (r_frame_cnt == CNT_MAX)) begin
        r_frame_cnt <= '0;
      end else begin
        r_frame_cnt <= r_frame_cnt + CNT_W'(1);
      end
    end
  end

  assign w_phase = (r_frame_cnt >= CNT_HALF);

  // Colour select; phase is read live here so the animation needs no extra delay line
  always_comb begin
    w_color = BG_COLOR;
    w_hit   = 1'b0;
    if (w_reg_d && !w_mask) begin
      unique case (r_mode_q)
        OV_ALT: begin
          w_color = w_phase ? FG_B : FG_A;
          w_hit   = 1'b1;
        end
        OV_BLINK: begin
          w_color = w_phase ? BG_COLOR : FG_A;
          w_hit   = !w_phase;
        end
        default: begin
          w_color = FG_A;
          w_hit   = 1'b1;
        end
      endcase
    end
  end

  // Final stage: registered colour and flags, aligned with each other
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      bus.ov_r      <= BG_COLOR[11:8];
      bus.ov_g      <= BG_COLOR[7:4];
      bus.ov_b      <= BG_COLOR[3:0];
      bus.in_region <= 1'b0;
      bus.hit       <= 1'b0;
    end else begin
      bus.ov_r      <= w_color[11:8];
      bus.ov_g      <= w_color[7:4];
      bus.ov_b      <= w_color[3:0];
      bus.in_region <= w_reg_d;
      bus.hit       <= w_hit;
    end
  end

endmodule
